mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multi-cycle MIPS control unit: Moore main FSM plus ALU decoder. Sits inside top beside the
//  64-bit datapath; consumes instr[31:26]/[5:0] and ALU zero, drives every datapath mux/enable
//  and the memwrite strobe seen at top level. One instruction = 3-5 cycles; counts retirements.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  reset        in   1      synchronous, active-high
//  op           in   6      instr[31:26] from instruction register
//  funct        in   6      instr[5:0]
//  zero         in   1      ALU result == 0 (64-bit compare, from datapath)
//  pcen         out  1      PC write enable = pcwrite | (branch & zero)
//  memwrite     out  1      data memory write strobe
//  irwrite      out  1      instruction register load
//  regwrite     out  1      register file write
//  iord         out  1      0: mem addr = PC, 1: mem addr = ALUOut
//  memtoreg     out  1      0: wb ALUOut, 1: wb Data reg
//  regdst       out  1      0: rt, 1: rd
//  alusrca      out  1      0: PC, 1: A
//  alusrcb      out  2      00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//  pcsrc        out  2      00 ALUResult, 01 ALUOut, 10 jump target
//  alucontrol   out  3      010 add, 110 sub, 000 and, 001 or, 111 slt
//  instr_done   out  1      1-cycle pulse in the final state of each instruction
//  instret      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - Reset: state<=FETCH, instret<=0 on clock edge. While reset=1 pcen, memwrite, irwrite,
//    regwrite, instr_done forced 0 regardless of state (mid-instruction reset aborts cleanly).
//  - Outputs are pure functions of state (plus funct for alucontrol, zero for pcen); no latency.
//  - Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
//  - States/transitions (unlisted outputs 0):
//    FETCH   iord0 alusrca0 alusrcb01 aluop00 pcsrc00 irwrite1 pcwrite1     -> DECODE
//    DECODE  alusrca0 alusrcb11 aluop00 -> LW/SW:MEMADR RTYPE:RTYPEEX BEQ:BEQEX ADDI:ADDIEX J:JEX
//            any other op -> FETCH (illegal opcode: treated as NOP, no retire pulse)
//    MEMADR  alusrca1 alusrcb10 aluop00                -> LW:MEMRD  SW:MEMWR
//    MEMRD   iord1                                     -> MEMWB
//    MEMWB   regdst0 memtoreg1 regwrite1 done          -> FETCH
//    MEMWR   iord1 memwrite1 done                      -> FETCH
//    RTYPEEX alusrca1 alusrcb00 aluop10                -> RTYPEWB
//    RTYPEWB regdst1 memtoreg0 regwrite1 done          -> FETCH
//    BEQEX   alusrca1 alusrcb00 aluop01 pcsrc01 branch1 done -> FETCH
//    ADDIEX  alusrca1 alusrcb10 aluop00                -> ADDIWB
//    ADDIWB  regdst0 memtoreg0 regwrite1 done          -> FETCH
//    JEX     pcsrc10 pcwrite1 done                     -> FETCH
//  - ALU decode: aluop00->010, 01->110, 10->by funct (100000 add 010, 100010 sub 110,
//    100100 and 000, 100101 or 001, 101010 slt 111); unknown funct -> 010, still retires.
//  - Cycle counts: LW 5, SW/RTYPE/ADDI 4, BEQ/J 3.
//  - instret increments by 1 on each cycle instr_done=1; wraps modulo 2^CNT_W, no saturation.
//  - Unused state encodings -> FETCH next cycle, all enables 0 (no X propagation).
// STRUCTURE
//  - Shared package mc_pkg: state enum (4-bit), opcode/funct localparams, aluop codes,
//    alusrcb/pcsrc select codes (also used by datapath muxes).
//  - Sub-module mc_alu_decoder (aluop, funct -> alucontrol), combinational.
//  - Top-level: state register, next-state logic, output decode, instret counter.
// TESTING
//  - Reset held 3 cycles in MEMWR state -> memwrite=0 during reset; FETCH outputs next cycle, instret=0.
//  - op=100011 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 only in cycle 5; instret 0->1.
//  - op=000000 funct=101010 -> alucontrol=111 in RTYPEEX; regdst=1 regwrite=1 in cycle 4.
//  - op=000100 zero=1 -> pcen=1 in BEQEX; repeat with zero=0 -> pcen=0; both pulse instr_done.
//  - op=111111 -> FETCH,DECODE,FETCH; no enables, instret unchanged.
//  - Preload instret=FFFFFFFF via forced count, run J (op=000010) -> 3 cycles, pcsrc=10, instret wraps to 0.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// opcode/funct values, ALU op classes and the datapath mux select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Select codes shared with the datapath muxes.
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSHL = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the datapath (master: drives instruction fields and zero)
// and the control unit (slave: drives every mux select and enable).
interface mc_control_fsm_if #(parameter int CNT_W = 32);
  import mc_pkg::*;

  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             pcen;
  logic             memwrite;
  logic             irwrite;
  logic             regwrite;
  logic             iord;
  logic             memtoreg;
  logic             regdst;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       pcsrc;
  logic [2:0]       alucontrol;
  logic             instr_done;
  logic [CNT_W-1:0] instret;

  modport master (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, alucontrol, instr_done, instret
  );

  modport slave (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, alucontrol, instr_done, instret
  );

endinterface

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU decoder: maps the FSM's ALU op class plus the R-type funct field to an
// ALU control code. Unknown funct values fall back to add.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: Moore main FSM, ALU decoder and a
// retired-instruction counter that steps once per instr_done pulse.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  mc_control_fsm_if.slave  bus
);

  state_t           state, next_state;
  aluop_t           aluop;
  logic             pcwrite, branch, done;
  logic             memwrite_s, irwrite_s, regwrite_s;
  logic             iord_s, memtoreg_s, regdst_s, alusrca_s;
  logic [1:0]       alusrcb_s, pcsrc_s;
  logic [2:0]       alucontrol_s;
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Outputs depend on state only; unused encodings fall into default and
  // return to FETCH with every enable low.
  always_comb begin
    next_state = S_FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    done       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    iord_s     = 1'b0;
    memtoreg_s = 1'b0;
    regdst_s   = 1'b0;
    alusrca_s  = 1'b0;
    alusrcb_s  = SRCB_B;
    pcsrc_s    = PCSRC_ALU;
    aluop      = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        alusrcb_s  = SRCB_FOUR;
        irwrite_s  = 1'b1;
        pcwrite    = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        alusrcb_s = SRCB_IMMSHL;
        case (bus.op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_RTYPEEX;
          OP_BEQ:       next_state = S_BEQEX;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JEX;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca_s  = 1'b1;
        alusrcb_s  = SRCB_IMM;
        next_state = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord_s     = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
        done       = 1'b1;
      end
      S_MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
        done       = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca_s  = 1'b1;
        aluop      = ALUOP_FUNCT;
        next_state = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
        done       = 1'b1;
      end
      S_BEQEX: begin
        alusrca_s = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc_s   = PCSRC_ALUOUT;
        branch    = 1'b1;
        done      = 1'b1;
      end
      S_ADDIEX: begin
        alusrca_s  = 1'b1;
        alusrcb_s  = SRCB_IMM;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_s = 1'b1;
        done       = 1'b1;
      end
      S_JEX: begin
        pcsrc_s = PCSRC_JUMP;
        pcwrite = 1'b1;
        done    = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (alucontrol_s)
  );

  always_ff @(posedge clk) begin
    if (reset)     instret_q <= '0;
    else if (done) instret_q <= instret_q + CNT_W'(1);
  end

  // Reset masks every side-effecting strobe so an aborted instruction leaves no trace.
  assign bus.pcen       = ~reset & (pcwrite | (branch & bus.zero));
  assign bus.memwrite   = ~reset & memwrite_s;
  assign bus.irwrite    = ~reset & irwrite_s;
  assign bus.regwrite   = ~reset & regwrite_s;
  assign bus.instr_done = ~reset & done;
  assign bus.iord       = iord_s;
  assign bus.memtoreg   = memtoreg_s;
  assign bus.regdst     = regdst_s;
  assign bus.alusrca    = alusrca_s;
  assign bus.alusrcb    = alusrcb_s;
  assign bus.pcsrc      = pcsrc_s;
  assign bus.alucontrol = alucontrol_s;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-cycle expected control words queued per
// instruction, plus a narrow-counter twin instance that shows wraparound.
module tb_mc_control_fsm;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
  } vec_t;

  typedef struct {
    string       tag;
    logic [15:0] word;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] model_cnt;
  exp_t exp_q[$];
  vec_t vecs[14];

  mc_control_fsm_if #(.CNT_W(32)) big_if ();
  mc_control_fsm_if #(.CNT_W(4))  small_if ();

  mc_control_fsm #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (big_if.slave)
  );

  mc_control_fsm #(.CNT_W(4)) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (small_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs the control outputs as {pcen,memwrite,irwrite,regwrite,iord,memtoreg,
  // regdst,alusrca,alusrcb,pcsrc,alucontrol,instr_done}.
  function automatic logic [15:0] mk(logic pcen, logic mw, logic irw, logic rw,
                                     logic iord, logic m2r, logic rd, logic sa,
                                     logic [1:0] sb, logic [1:0] ps,
                                     logic [2:0] ac, logic dn);
    return {pcen, mw, irw, rw, iord, m2r, rd, sa, sb, ps, ac, dn};
  endfunction

  function automatic logic [2:0] exp_alu(logic [5:0] funct);
    case (funct)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  localparam logic [15:0] W_FETCH     = 16'b1010_0000_0100_0100;
  localparam logic [15:0] W_FETCH_RST = 16'b0000_0000_0100_0100;
  localparam logic [15:0] W_DECODE    = 16'b0000_0000_1100_0100;
  localparam logic [15:0] W_MEMADR    = 16'b0000_0001_1000_0100;
  localparam logic [15:0] W_MEMRD     = 16'b0000_1000_0000_0100;
  localparam logic [15:0] W_MEMWB     = 16'b0001_0100_0000_0101;
  localparam logic [15:0] W_MEMWR     = 16'b0100_1000_0000_0101;
  localparam logic [15:0] W_MEMWR_RST = 16'b0000_1000_0000_0100;
  localparam logic [15:0] W_RTYPEWB   = 16'b0001_0010_0000_0101;
  localparam logic [15:0] W_ADDIEX    = 16'b0000_0001_1000_0100;
  localparam logic [15:0] W_ADDIWB    = 16'b0001_0000_0000_0101;
  localparam logic [15:0] W_JEX       = 16'b1000_0000_0010_0101;

  task automatic checkOutput(input string tag, input logic [15:0] exp_word,
                             input logic [31:0] exp_cnt);
    logic [15:0] act;
    act = {big_if.pcen, big_if.memwrite, big_if.irwrite, big_if.regwrite,
           big_if.iord, big_if.memtoreg, big_if.regdst, big_if.alusrca,
           big_if.alusrcb, big_if.pcsrc, big_if.alucontrol, big_if.instr_done};
    total++;
    if (act !== exp_word) begin
      bad++;
      $display("[TB] FAIL %s ctrl: got %b want %b", tag, act, exp_word);
    end
    total++;
    if (big_if.instret !== exp_cnt) begin
      bad++;
      $display("[TB] FAIL %s instret: got %0d want %0d", tag, big_if.instret, exp_cnt);
    end
    total++;
    if (small_if.instret !== exp_cnt[3:0]) begin
      bad++;
      $display("[TB] FAIL %s instret4: got %0d want %0d", tag, small_if.instret, exp_cnt[3:0]);
    end
  endtask

  task automatic step_check(input string tag, input logic [15:0] w, input logic [31:0] c);
    #1;
    checkOutput(tag, w, c);
    @(negedge clk);
  endtask

  task automatic push_exp(input string tag, input logic [15:0] w, input logic is_done);
    exp_t e;
    e.tag  = tag;
    e.word = w;
    e.cnt  = model_cnt;
    exp_q.push_back(e);
    if (is_done) model_cnt = model_cnt + 32'd1;
  endtask

  task automatic set_inputs(input logic [5:0] op, input logic [5:0] funct, input logic zero);
    big_if.op      = op;
    big_if.funct   = funct;
    big_if.zero    = zero;
    small_if.op    = op;
    small_if.funct = funct;
    small_if.zero  = zero;
  endtask

  // Drives one instruction, queues its expected cycle-by-cycle outputs, then
  // pops and compares one entry per cycle. Entered and left at a FETCH negedge.
  task automatic applyStimulus(input string name, input logic [5:0] op,
                               input logic [5:0] funct, input logic zero);
    exp_t e;
    set_inputs(op, funct, zero);
    push_exp({name, "/fetch"}, W_FETCH, 1'b0);
    push_exp({name, "/decode"}, W_DECODE, 1'b0);
    case (op)
      6'b100011: begin
        push_exp({name, "/memadr"}, W_MEMADR, 1'b0);
        push_exp({name, "/memrd"}, W_MEMRD, 1'b0);
        push_exp({name, "/memwb"}, W_MEMWB, 1'b1);
      end
      6'b101011: begin
        push_exp({name, "/memadr"}, W_MEMADR, 1'b0);
        push_exp({name, "/memwr"}, W_MEMWR, 1'b1);
      end
      6'b000000: begin
        push_exp({name, "/rtypeex"},
                 mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, exp_alu(funct), 0), 1'b0);
        push_exp({name, "/rtypewb"}, W_RTYPEWB, 1'b1);
      end
      6'b000100:
        push_exp({name, "/beqex"},
                 mk(zero, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 1), 1'b1);
      6'b001000: begin
        push_exp({name, "/addiex"}, W_ADDIEX, 1'b0);
        push_exp({name, "/addiwb"}, W_ADDIWB, 1'b1);
      end
      6'b000010:
        push_exp({name, "/jex"}, W_JEX, 1'b1);
      default: ;
    endcase
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step_check(e.tag, e.word, e.cnt);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    model_cnt = 32'd0;
    vecs[0]  = '{"lw",       6'b100011, 6'b000000, 1'b0};
    vecs[1]  = '{"sw",       6'b101011, 6'b000000, 1'b0};
    vecs[2]  = '{"add",      6'b000000, 6'b100000, 1'b0};
    vecs[3]  = '{"sub",      6'b000000, 6'b100010, 1'b0};
    vecs[4]  = '{"and",      6'b000000, 6'b100100, 1'b0};
    vecs[5]  = '{"or",       6'b000000, 6'b100101, 1'b0};
    vecs[6]  = '{"slt",      6'b000000, 6'b101010, 1'b0};
    vecs[7]  = '{"badfunct", 6'b000000, 6'b000111, 1'b0};
    vecs[8]  = '{"beq_tk",   6'b000100, 6'b000000, 1'b1};
    vecs[9]  = '{"beq_nt",   6'b000100, 6'b000000, 1'b0};
    vecs[10] = '{"addi",     6'b001000, 6'b000000, 1'b0};
    vecs[11] = '{"j",        6'b000010, 6'b000000, 1'b0};
    vecs[12] = '{"illegal",  6'b111111, 6'b000000, 1'b0};
    vecs[13] = '{"illegal1", 6'b000001, 6'b101010, 1'b1};

    reset = 1'b1;
    set_inputs(6'b000000, 6'b000000, 1'b0);
    @(negedge clk);
    step_check("reset_state", W_FETCH_RST, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].zero);

    // Abort a store in its write cycle; the strobe must never reach memory.
    set_inputs(6'b101011, 6'b000000, 1'b0);
    step_check("abort/fetch", W_FETCH, model_cnt);
    step_check("abort/decode", W_DECODE, model_cnt);
    step_check("abort/memadr", W_MEMADR, model_cnt);
    reset = 1'b1;
    step_check("abort/rst_memwr", W_MEMWR_RST, model_cnt);
    step_check("abort/rst_fetch1", W_FETCH_RST, 32'd0);
    step_check("abort/rst_fetch2", W_FETCH_RST, 32'd0);
    reset = 1'b0;
    model_cnt = 32'd0;

    // Sixteen jumps roll the 4-bit twin counter over to zero.
    for (int i = 0; i < 16; i++)
      applyStimulus($sformatf("wrap_j%0d", i), 6'b000010, 6'b000000, 1'b0);
    step_check("wrap_final", W_FETCH, model_cnt);
    total++;
    if (small_if.instret !== 4'd0) begin
      bad++;
      $display("[TB] FAIL wrap_zero: got %0d want 0", small_if.instret);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
